// File: rtl/width_pack_fifo.sv
// Narrow-write / wide-read packing FIFO: gathers lpm_width_w-bit flits into
// lpm_width-bit words (lane 0 first) and offers them through a show-ahead read port.
module width_pack_fifo #(
    parameter int lpm_width_w  = 128,
    parameter int lpm_width    = 512,
    parameter int lpm_numwords = 8,
    localparam int R  = lpm_width / lpm_width_w,
    localparam int LW = $clog2(R) + 1,
    localparam int UW = $clog2(lpm_numwords) + 1
) (
    input  logic                   clock,
    input  logic                   aclr_n,
    input  logic [lpm_width_w-1:0] data,
    input  logic                   wrreq,
    input  logic                   flush,
    output logic                   wrfull,
    input  logic                   rdreq,
    output logic [lpm_width-1:0]   q,
    output logic [LW-1:0]          q_lanes,
    output logic                   rdempty,
    output logic [UW-1:0]          usedw,
    output logic [LW-2:0]          lane_cnt
);

    localparam int AW = UW - 1;
    localparam logic [LW-2:0] LANE_ONE  = (LW-1)'(1);
    localparam logic [LW-2:0] LANE_LAST = (LW-1)'(R - 1);
    localparam logic [LW-1:0] LANES_ONE = LW'(1);
    localparam logic [UW-1:0] PTR_ONE   = UW'(1);
    localparam logic [UW-1:0] FULL_CNT  = UW'(lpm_numwords);

    logic [lpm_width-1:0] pack_q, pack_d;
    logic [LW-2:0]        lane_q, lane_d;
    logic [UW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [UW-1:0]        rd_ptr_q, rd_ptr_d;

    logic [lpm_width-1:0] mem_data  [lpm_numwords];
    logic [LW-1:0]        mem_lanes [lpm_numwords];

    logic                 accept, push, pop;
    logic [lpm_width-1:0] merged;
    logic [LW-1:0]        push_lanes;

    // Status comes only from registered pointers, so rdreq never reaches wrfull.
    assign usedw    = wr_ptr_q - rd_ptr_q;
    assign wrfull   = (usedw == FULL_CNT);
    assign rdempty  = (usedw == '0);
    assign lane_cnt = lane_q;

    assign accept = wrreq && !wrfull;
    assign pop    = rdreq && !rdempty;
    assign push   = (accept && (lane_q == LANE_LAST)) ||
                    (flush && !wrfull && (accept || (lane_q != '0)));

    assign push_lanes = accept ? ({1'b0, lane_q} + LANES_ONE) : {1'b0, lane_q};

    // Lanes above lane_q are always zero in the pack register, so a flush pads with zeros.
    always_comb begin
        merged = pack_q;
        for (int i = 0; i < R; i++) begin
            if (accept && (lane_q == (LW-1)'(i))) begin
                merged[i*lpm_width_w +: lpm_width_w] = data;
            end
        end
    end

    always_comb begin
        pack_d   = pack_q;
        lane_d   = lane_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            pack_d   = '0;
            lane_d   = '0;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else if (accept) begin
            pack_d = merged;
            lane_d = lane_q + LANE_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            pack_q   <= '0;
            lane_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            pack_q   <= pack_d;
            lane_q   <= lane_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage contents are don't-care after reset; only the pointers matter.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_data[wr_ptr_q[AW-1:0]]  <= merged;
            mem_lanes[wr_ptr_q[AW-1:0]] <= push_lanes;
        end
    end

    assign q       = mem_data[rd_ptr_q[AW-1:0]];
    assign q_lanes = mem_lanes[rd_ptr_q[AW-1:0]];

endmodule
